multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle CPU control unit. It sequences each instruction through IF/ID/EXE/MEM/WB and drives the data memory stage's MemWrite, MemToReg, loadStoreWidth and loadSign inputs, plus the PC, IR, ALU and register-file controls. It sits directly upstream of the data memory: it decodes the IR opcode and branch-zero flag into per-cycle strobes for the datapath.

Parameters:
OPW, 6, opcode width (fixed MIPS encoding below)

Ports:
CLK  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], held stable by datapath after IF
zero  in  1  ALU zero flag, valid in EXE
state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111
PCWrite  out  1  PC load enable
PCSrc  out  2  00 = PC+4, 01 = branch target, 10 = jump target
IRWrite  out  1  IR load enable
RegDst  out  1  1 = rd, 0 = rt
ALUSrcB  out  1  1 = sign-extended immediate, 0 = rt data
ALUOp  out  3  000 = add, 001 = sub, 010 = funct-decoded
RegWrite  out  1  register-file write enable
MemWrite  out  1  data memory write strobe
MemToReg  out  1  1 = write back memory data, 0 = ALU result
loadStoreWidth  out  2  00 = byte, 01 = halfword, 11 = word
loadSign  out  1  1 = sign-extend sub-word loads

Behaviour:
- Opcodes:
  - R-type 000000; addi 001000; beq 000100; j 000010; halt 111111.
  - lb 100000; lh 100001; lw 100011; lbu 100100; lhu 100101.
  - sb 101000; sh 101001; sw 101011.
  - Any other opcode is illegal and is treated as a nop.
- State register: updates only on the rising edge of CLK. Reset asynchronously forces state = IF.
- While Reset is high, every enable output is 0: PCWrite, IRWrite, RegWrite, MemWrite, MemToReg.
- Reset values of the remaining outputs: PCSrc = 00, ALUOp = 000, RegDst = 0, ALUSrcB = 0, loadStoreWidth = 11, loadSign = 0.
- Outputs are combinational from (state, opcode, zero); the state register is the only storage.
- Transitions:
  - IF -> ID always.
  - ID -> IF for j, illegal opcodes and R/I opcodes that need no further stage.
  - ID -> HALT for halt.
  - ID -> EXE for R-type, addi, beq, loads and stores.
  - EXE -> IF for beq; EXE -> MEM for loads/stores; EXE -> WB for R-type and addi.
  - MEM -> WB for loads; MEM -> IF for stores.
  - WB -> IF.
  - HALT -> HALT until Reset.
- Per-state outputs (all unlisted enables are 0):
  - IF: PCWrite = 1, IRWrite = 1, PCSrc = 00.
  - ID, opcode j: PCWrite = 1, PCSrc = 10.
  - EXE, R-type: ALUSrcB = 0, ALUOp = 010.
  - EXE, addi/load/store: ALUSrcB = 1, ALUOp = 000.
  - EXE, beq: ALUSrcB = 0, ALUOp = 001, PCSrc = 01, PCWrite = zero.
  - MEM, store: MemWrite = 1, for exactly one cycle per store.
  - MEM, load: MemToReg = 1.
  - WB: RegWrite = 1. MemToReg = 1 for loads, 0 otherwise. RegDst = 1 only for R-type.
  - HALT: all enables 0; PC frozen.
- Width and sign decode from opcode, in every state:
  - Byte ops (lb, lbu, sb): width 00. Halfword ops (lh, lhu, sh): width 01. All others: width 11.
  - loadSign = 1 for lb and lh only.
  - Width and sign therefore stay stable across EXE, MEM and WB.
- Instruction latency in cycles: j = 2, halt = 2 then stall, beq = 3, R-type/addi = 4, store = 4, load = 5.
- Boundary conditions:
  - Opcode change outside IF is ignored for transitions; the datapath holds IR.
  - Reset asserted mid-instruction: state = IF immediately (asynchronous); a pending MemWrite/RegWrite is dropped.
  - Reset deasserted: the first rising edge moves IF -> ID.
  - beq with zero = 0: PCWrite = 0 and the next state is still IF.

Test Plan:
- Reset pulse mid-MEM of sw -> state = 000 immediately, MemWrite = 0 during reset; after release, state sequence 000 -> 001 -> 010.
- sb (101000) -> states IF, ID, EXE, MEM, IF; MemWrite = 1 only in MEM; loadStoreWidth = 00; RegWrite never 1.
- lh (100001) -> IF, ID, EXE, MEM, WB; loadStoreWidth = 01, loadSign = 1; MemToReg = 1 in MEM and WB; RegWrite = 1 only in WB. Repeat with lhu (100101) -> loadSign = 0.
- lw (100011) -> loadStoreWidth = 11, loadSign = 0, 5-cycle latency. Repeat with R-type 000000 -> 4 cycles, RegDst = 1, ALUOp = 010 in EXE.
- beq (000100) with zero = 1 -> PCWrite = 1, PCSrc = 01 in EXE. Repeat with zero = 0 -> PCWrite = 0. Both return to IF after 3 cycles.
- j (000010) -> PCWrite = 1, PCSrc = 10 in ID, back to IF. Illegal opcode 110011 -> ID -> IF, no enables. halt (111111) -> state 111 held for 10 cycles with all enables 0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit: steps each instruction through IF/ID/EXE/MEM/WB
// and decodes (state, opcode, zero) into per-cycle datapath strobes.
module multi_cycle_ctrl #(
  parameter int OPW = 6
) (
  input  logic           CLK,
  input  logic           Reset,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic [2:0]     state,
  output logic           PCWrite,
  output logic [1:0]     PCSrc,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           RegWrite,
  output logic           MemWrite,
  output logic           MemToReg,
  output logic [1:0]     loadStoreWidth,
  output logic           loadSign
);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);
  localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_LH    = OPW'(6'b100001);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_LBU   = OPW'(6'b100100);
  localparam logic [OPW-1:0] OP_LHU   = OPW'(6'b100101);
  localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
  localparam logic [OPW-1:0] OP_SH    = OPW'(6'b101001);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

  state_t state_q, state_d;

  logic is_rtype, is_addi, is_beq, is_j, is_halt, is_load, is_store;
  logic is_byte, is_half, is_signed;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_addi   = (opcode == OP_ADDI);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_j      = (opcode == OP_J);
  assign is_halt   = (opcode == OP_HALT);
  assign is_load   = (opcode == OP_LB) || (opcode == OP_LH) || (opcode == OP_LW) ||
                     (opcode == OP_LBU) || (opcode == OP_LHU);
  assign is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
  assign is_byte   = (opcode == OP_LB) || (opcode == OP_LBU) || (opcode == OP_SB);
  assign is_half   = (opcode == OP_LH) || (opcode == OP_LHU) || (opcode == OP_SH);
  assign is_signed = (opcode == OP_LB) || (opcode == OP_LH);

  // The datapath holds IR after IF, so opcode is stable for every decision below.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID: begin
        if (is_halt)
          state_d = S_HALT;
        else if (is_rtype || is_addi || is_beq || is_load || is_store)
          state_d = S_EXE;
        else
          state_d = S_IF;
      end
      S_EXE: begin
        if (is_load || is_store)
          state_d = S_MEM;
        else if (is_rtype || is_addi)
          state_d = S_WB;
        else
          state_d = S_IF;
      end
      S_MEM:  state_d = is_load ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Reset overrides the decode so IF's fetch strobes never fire while held in reset.
  always_comb begin
    PCWrite        = 1'b0;
    PCSrc          = 2'b00;
    IRWrite        = 1'b0;
    RegDst         = 1'b0;
    ALUSrcB        = 1'b0;
    ALUOp          = 3'b000;
    RegWrite       = 1'b0;
    MemWrite       = 1'b0;
    MemToReg       = 1'b0;
    loadStoreWidth = 2'b11;
    loadSign       = 1'b0;
    if (!Reset) begin
      loadStoreWidth = is_byte ? 2'b00 : (is_half ? 2'b01 : 2'b11);
      loadSign       = is_signed;
      case (state_q)
        S_IF: begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
        end
        S_ID: begin
          if (is_j) begin
            PCWrite = 1'b1;
            PCSrc   = 2'b10;
          end
        end
        S_EXE: begin
          if (is_rtype) begin
            ALUOp = 3'b010;
          end else if (is_beq) begin
            ALUOp   = 3'b001;
            PCSrc   = 2'b01;
            PCWrite = zero;
          end else begin
            ALUSrcB = 1'b1;
          end
        end
        S_MEM: begin
          MemWrite = is_store;
          MemToReg = is_load;
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemToReg = is_load;
          RegDst   = is_rtype;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: a per-instruction expected-cycle list
// is built from the opcode rules and compared cycle by cycle against the DUT.
module tb_multi_cycle_ctrl;

  localparam int W = 18;

  logic       CLK, Reset, zero;
  logic [5:0] opcode;
  logic [2:0] state;
  logic       PCWrite, IRWrite, RegDst, ALUSrcB, RegWrite, MemWrite, MemToReg, loadSign;
  logic [1:0] PCSrc, loadStoreWidth;
  logic [2:0] ALUOp;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  int n_tests = 0;
  int n_fail  = 0;

  multi_cycle_ctrl #(.OPW(6)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero), .state(state),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .RegDst(RegDst),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemToReg(MemToReg), .loadStoreWidth(loadStoreWidth), .loadSign(loadSign)
  );

  assign obs = {state, PCWrite, PCSrc, IRWrite, RegDst, ALUSrcB, ALUOp,
                RegWrite, MemWrite, MemToReg, loadStoreWidth, loadSign};

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected value while Reset is held: IF state, enables off, width 11.
  localparam logic [W-1:0] RESET_VEC = {3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000,
                                        1'b0, 1'b0, 1'b0, 2'b11, 1'b0};

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (op=%b zero=%b t=%0t)", tag, got, exp, opcode, zero, $time);
    end
  endtask

  // Reference model: an instruction is a list of stages; each stage's strobes follow the opcode rules.
  typedef enum int {K_RTYPE, K_ADDI, K_BEQ, K_J, K_HALT, K_LOAD, K_STORE, K_NOP} kind_t;

  function automatic kind_t kind_of(input logic [5:0] op);
    case (op)
      6'b000000: return K_RTYPE;
      6'b001000: return K_ADDI;
      6'b000100: return K_BEQ;
      6'b000010: return K_J;
      6'b111111: return K_HALT;
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: return K_LOAD;
      6'b101000, 6'b101001, 6'b101011: return K_STORE;
      default: return K_NOP;
    endcase
  endfunction

  // stage: 0=IF 1=ID 2=EXE 3=MEM 4=WB 5=HALT
  function automatic logic [W-1:0] stage_vec(input int stage, input logic [5:0] op, input logic z);
    logic [2:0] st_codes [6];
    logic [2:0] st, aop;
    logic [1:0] pcsrc, wid;
    logic pcw, irw, rdst, asb, rw, mw, m2r, sgn;
    kind_t k;
    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    k = kind_of(op);
    st = st_codes[stage];
    {pcw, irw, rdst, asb, rw, mw, m2r} = '0;
    pcsrc = 2'b00;
    aop = 3'b000;
    if (op == 6'b100000 || op == 6'b100100 || op == 6'b101000)      wid = 2'b00;
    else if (op == 6'b100001 || op == 6'b100101 || op == 6'b101001) wid = 2'b01;
    else                                                              wid = 2'b11;
    sgn = (op == 6'b100000 || op == 6'b100001);
    if (stage == 0) begin
      pcw = 1'b1; irw = 1'b1;
    end else if (stage == 1 && k == K_J) begin
      pcw = 1'b1; pcsrc = 2'b10;
    end else if (stage == 2) begin
      if (k == K_RTYPE) aop = 3'b010;
      else if (k == K_BEQ) begin aop = 3'b001; pcsrc = 2'b01; pcw = z; end
      else asb = 1'b1;
    end else if (stage == 3) begin
      mw = (k == K_STORE); m2r = (k == K_LOAD);
    end else if (stage == 4) begin
      rw = 1'b1; m2r = (k == K_LOAD); rdst = (k == K_RTYPE);
    end
    return {st, pcw, pcsrc, irw, rdst, asb, aop, rw, mw, m2r, wid, sgn};
  endfunction

  function automatic void model(input logic [5:0] op, input logic z, input int halt_cycles);
    kind_t k = kind_of(op);
    exp_q.push_back(stage_vec(0, op, z));
    exp_q.push_back(stage_vec(1, op, z));
    if (k == K_HALT) begin
      for (int i = 0; i < halt_cycles; i++) exp_q.push_back(stage_vec(5, op, z));
    end else if (k != K_J && k != K_NOP) begin
      exp_q.push_back(stage_vec(2, op, z));
      if (k == K_LOAD || k == K_STORE) exp_q.push_back(stage_vec(3, op, z));
      if (k == K_LOAD || k == K_RTYPE || k == K_ADDI) exp_q.push_back(stage_vec(4, op, z));
    end
  endfunction

  // Driver: entered just after a rising edge with the DUT in IF. Checks n_chk cycles;
  // a partial run stops at the negedge of the last checked cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z, input int n_chk);
    int total;
    opcode = op;
    zero   = z;
    model(op, z, 10);
    total = exp_q.size();
    if (n_chk <= 0 || n_chk > total) n_chk = total;
    for (int i = 0; i < n_chk; i++) begin
      @(negedge CLK);
      check_eq(tag, obs, exp_q.pop_front());
      if (i < n_chk - 1 || n_chk == total) begin
        @(posedge CLK);
        #1;
      end
    end
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    #2 Reset = 1'b1;
    #1 check_eq({tag, "_async"}, obs, RESET_VEC);
    @(negedge CLK);
    check_eq({tag, "_hold"}, obs, RESET_VEC);
    @(posedge CLK);
    #1 Reset = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] legal [13];
    logic [5:0] op;
    legal = '{6'b000000, 6'b001000, 6'b000100, 6'b000010, 6'b111111,
              6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
              6'b101000, 6'b101001, 6'b101011};
    if ($urandom_range(0, 5) != 0) return legal[$urandom_range(0, 12)];
    do op = 6'($urandom_range(0, 63)); while (kind_of(op) != K_NOP);
    return op;
  endfunction

  initial begin
    logic [5:0] op;
    Reset  = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_eq("reset_state", obs, RESET_VEC);
    @(posedge CLK);
    #1 Reset = 1'b0;

    run_instr("sb",      6'b101000, 1'b0, 0);
    run_instr("lh",      6'b100001, 1'b0, 0);
    run_instr("lhu",     6'b100101, 1'b1, 0);
    run_instr("lw",      6'b100011, 1'b0, 0);
    run_instr("rtype",   6'b000000, 1'b0, 0);
    run_instr("beq_z1",  6'b000100, 1'b1, 0);
    run_instr("beq_z0",  6'b000100, 1'b0, 0);
    run_instr("j",       6'b000010, 1'b0, 0);
    run_instr("illegal", 6'b110011, 1'b0, 0);
    run_instr("addi",    6'b001000, 1'b1, 0);

    // Interrupt sw while it is in MEM, then confirm the restart sequence.
    run_instr("sw_pre",  6'b101011, 1'b0, 4);
    do_reset("rst_mem");
    run_instr("sw_post", 6'b101011, 1'b0, 0);

    for (int n = 0; n < 80; n++) begin
      op = rand_op();
      run_instr("rand", op, 1'($urandom_range(0, 1)), 0);
      if (kind_of(op) == K_HALT) do_reset("rst_halt");
    end

    run_instr("halt", 6'b111111, 1'b0, 0);
    do_reset("rst_final");
    run_instr("lb_after", 6'b100000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
